// File: rtl/matmul_2x2_seq_ctrl.sv
// Sequencing controller for a 2x2 unsigned matrix product.
// One shared EW x EW multiplier, one product per clock, full-precision results.
module matmul_2x2_seq_ctrl #(
  parameter  int EW = 4,
  localparam int CW = 2*EW+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4*EW-1:0] a_in,
  input  logic [4*EW-1:0] b_in,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4*CW-1:0] c_out,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t               state;
  logic [3:0][EW-1:0]   a_r, b_r;
  logic [3:0][CW-1:0]   c_r;
  logic [2:0]           idx;
  logic [CW-1:0]        acc;
  logic [EW-1:0]        mul_a, mul_b;
  logic [2*EW-1:0]      prod;
  logic [CW-1:0]        sum;

  // idx = {i, j, k}: the product for step idx is a[i][k] * b[k][j].
  always_comb begin
    mul_a = a_r[{idx[2], idx[0]}];
    mul_b = b_r[{idx[0], idx[1]}];
    prod  = mul_a * mul_b;
    sum   = acc + CW'(prod);
  end

  assign c_out = c_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a_in;
            b_r      <= b_in;
            idx      <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC: begin
          // Abort wins over the step scheduled for this cycle.
          if (abort) begin
            state    <= IDLE;
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            if (!idx[0]) acc <= CW'(prod);
            else         c_r[idx[2:1]] <= sum;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_2x2_seq_ctrl.sv
// Scoreboard bench for matmul_2x2_seq_ctrl: expected results queued at accept,
// popped and compared when out_valid is seen.
module tb_matmul_2x2_seq_ctrl;
  localparam int EW = 4;
  localparam int CW = 2*EW+1;
  localparam int TMO = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [4*EW-1:0] a_in, b_in;
  logic [4*CW-1:0] c_out;

  int tests = 0, fails = 0;
  int cyc_cnt = 0, last_acc = 0;
  logic [4*CW-1:0] sb[$];

  matmul_2x2_seq_ctrl #(.EW(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .c_out(c_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [4*CW-1:0] model(input logic [4*EW-1:0] a, input logic [4*EW-1:0] b);
    int ae[4], be[4], c[4];
    for (int i = 0; i < 4; i++) begin
      ae[i] = int'((a >> (EW*i)) & 16'hF);
      be[i] = int'((b >> (EW*i)) & 16'hF);
    end
    c[0] = ae[0]*be[0] + ae[1]*be[2];
    c[1] = ae[0]*be[1] + ae[1]*be[3];
    c[2] = ae[2]*be[0] + ae[3]*be[2];
    c[3] = ae[2]*be[1] + ae[3]*be[3];
    return {CW'(c[3]), CW'(c[2]), CW'(c[1]), CW'(c[0])};
  endfunction

  // Present operands until accepted; returns on the falling edge after the accept edge.
  task automatic accept(input logic [4*EW-1:0] a, input logic [4*EW-1:0] b, input bit push);
    int n = 0;
    in_valid = 1'b1; a_in = a; b_in = b;
    while (!in_ready && n < TMO) begin @(negedge clk); n++; end
    tests++;
    if (n >= TMO) begin fails++; $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready); end
    last_acc = cyc_cnt + 1;
    @(negedge clk);
    in_valid = 1'b0;
    if (push) sb.push_back(model(a, b));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < TMO) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    tests++;
    if (c_out !== '0) begin fails++; $display("FAIL reset_c_out: got %h required 0", c_out); end
  endtask

  task automatic test_basic;
    int cyc;
    logic [4*CW-1:0] exp;
    out_ready = 1'b1;
    accept(16'h4321, 16'h8765, 1'b1);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL basic_busy: busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    wait_valid(cyc);
    tests++;
    if (cyc !== 8) begin fails++; $display("FAIL basic_latency: got %0d cycles required 8", cyc); end
    exp = sb.size() > 0 ? sb.pop_front() : 'x;
    tests++;
    if (c_out !== exp) begin fails++; $display("FAIL basic_model: got %h required %h", c_out, exp); end
    tests++;
    if (c_out !== {9'd50, 9'd43, 9'd22, 9'd19}) begin
      fails++; $display("FAIL basic_const: got %h required %h", c_out, {9'd50, 9'd43, 9'd22, 9'd19});
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_return: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_max;
    int cyc;
    logic [4*CW-1:0] exp;
    out_ready = 1'b1;
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    wait_valid(cyc);
    exp = sb.size() > 0 ? sb.pop_front() : 'x;
    tests++;
    if (c_out !== exp || c_out !== {4{9'h1C2}}) begin
      fails++; $display("FAIL max_operands: got %h required %h", c_out, {4{9'h1C2}});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [4*CW-1:0] exp, held;
    out_ready = 1'b0;
    accept(16'h2222, 16'h3333, 1'b1);
    wait_valid(cyc);
    held = c_out;
    exp = sb.size() > 0 ? sb.pop_front() : 'x;
    tests++;
    if (c_out !== exp) begin fails++; $display("FAIL bp_first: got %h required %h", c_out, exp); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a_in = 16'hABCD ^ 16'(i); b_in = 16'h5A5A;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || c_out !== held) begin
        fails++; $display("FAIL bp_hold: out_valid=%b in_ready=%b c_out=%h required 1 0 %h", out_valid, in_ready, c_out, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || c_out !== held) begin
      fails++; $display("FAIL bp_release: out_valid=%b c_out=%h required 0 %h", out_valid, c_out, held);
    end
    accept(16'h1234, 16'hFEDC, 1'b1);
    wait_valid(cyc);
    exp = sb.size() > 0 ? sb.pop_front() : 'x;
    tests++;
    if (c_out !== exp) begin fails++; $display("FAIL bp_next: got %h required %h", c_out, exp); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int cyc;
    bit seen = 1'b0;
    logic [4*CW-1:0] exp;
    out_ready = 1'b1;
    accept(16'h9876, 16'h4321, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL abort_idle: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
    end
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL abort_no_valid: out_valid seen=1 required 0"); end
    accept(16'h1001, 16'h8765, 1'b1);
    wait_valid(cyc);
    exp = sb.size() > 0 ? sb.pop_front() : 'x;
    tests++;
    if (c_out !== exp || c_out !== {9'd8, 9'd7, 9'd6, 9'd5}) begin
      fails++; $display("FAIL abort_identity: got %h required %h", c_out, {9'd8, 9'd7, 9'd6, 9'd5});
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    accept(16'h7777, 16'h9999, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || c_out !== '0) begin
      fails++; $display("FAIL async_reset: out_valid=%b busy=%b in_ready=%b c_out=%h required 0 0 1 0", out_valid, busy, in_ready, c_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_basic();
  endtask

  task automatic test_back_to_back;
    int cyc, prev;
    logic [4*CW-1:0] exp;
    out_ready = 1'b1;
    prev = -1;
    for (int n = 0; n < 3; n++) begin
      accept(16'($urandom), 16'($urandom), 1'b1);
      if (prev >= 0) begin
        tests++;
        if (last_acc - prev !== 10) begin
          fails++; $display("FAIL b2b_spacing: got %0d cycles required 10", last_acc - prev);
        end
      end
      prev = last_acc;
      wait_valid(cyc);
      exp = sb.size() > 0 ? sb.pop_front() : 'x;
      tests++;
      if (cyc !== 8 || c_out !== exp) begin
        fails++; $display("FAIL b2b_result%0d: got %h after %0d cycles required %h after 8", n, c_out, cyc, exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;
    @(negedge clk); @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_max();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
